draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 Parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 Parameter BG_COLOUR, default 3'b111, background fill colour (white).
REQ-004 Parameter TIMEOUT, default 16384, max cycles a client may hold a grant.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse starting a frame's draw sequence.
REQ-008 clear_req  in  1  one-cycle pulse requesting a full-screen background fill.
REQ-009 tile_req, score_req  in  1 each  client has pixels to draw this frame.
REQ-010 tile_x/score_x  in  8; tile_y/score_y  in  7; tile_colour/score_colour  in  3; tile_plot/score_plot  in  1: client pixel write.
REQ-011 tile_done, score_done  in  1 each  one-cycle pulse, client finished.
REQ-012 tile_gnt, score_gnt  out  1 each  client owns the pixel port.
REQ-013 vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1: pixel write to VGA adapter.
REQ-014 init_done  out  1  first post-reset fill complete; busy  out  1  state != IDLE.
REQ-015 overrun  out  1  sticky, frame_tick arrived while busy; timeout_err  out  1  sticky, a grant was revoked by timeout.

Function
REQ-016 FSM states SHALL be FILL, IDLE, TILE, SCORE; exactly one held at a time.
REQ-017 From reset the FSM SHALL enter FILL; FILL writes every pixel x=0..SCREEN_W-1, y=0..SCREEN_H-1 with BG_COLOUR, x fastest, one pixel per cycle (19200 plots at defaults), then goes to IDLE.
REQ-018 init_done SHALL rise the cycle IDLE is first entered after reset and stay 1 until reset.
REQ-019 In IDLE, a pending clear SHALL take priority over frame_tick: go to FILL.
REQ-020 In IDLE on frame_tick: go to TILE if tile_req, else SCORE if score_req, else stay IDLE.
REQ-021 TILE SHALL assert tile_gnt; on tile_done go to SCORE if score_req, else IDLE; SCORE asserts score_gnt and on score_done goes to IDLE.
REQ-022 At most one gnt SHALL be high in any cycle; gnt falls the cycle after done is sampled.
REQ-023 done from a non-granted client SHALL be ignored.
REQ-024 clear_req arriving outside IDLE SHALL be latched as pending and serviced at next IDLE; multiple requests collapse to one fill.
REQ-025 frame_tick arriving outside IDLE SHALL be dropped and set overrun; frame_tick and clear_req together in IDLE -> FILL and the tick is dropped (overrun set).
REQ-026 Pixel path SHALL be registered: the granted client's x/y/colour/plot appear on vga_* exactly 1 cycle later; non-granted plot never reaches vga_plot.
REQ-027 A client plot with x>=SCREEN_W or y>=SCREEN_H SHALL be suppressed (vga_plot=0).
REQ-028 A per-grant cycle counter SHALL revoke the grant after TIMEOUT cycles without done, set timeout_err, and advance as if done arrived.
REQ-029 vga_plot SHALL be 0 in IDLE and in the cycle after any state change out of TILE/SCORE.

Reset
REQ-030 While resetn=0 at a clock edge: state=FILL at fill origin, all gnt=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, init_done=0, busy=1, overrun=0, timeout_err=0, pending clear=0, counters=0.
REQ-031 Reset mid-FILL or mid-grant SHALL abort immediately and restart the fill from (0,0).

Structure
REQ-032 Package draw_pkg SHALL hold SCREEN_W/SCREEN_H defaults, colour codes (BG white, black), the state enum, and coordinate widths.
REQ-033 Sub-module screen_fill SHALL implement the x/y raster counter with start/busy/done and pixel outputs; draw_scheduler instantiates it once.

Verification
REQ-034 Reset release -> 19200 vga_plot pulses with colour 3'b111 covering (0,0)..(159,119) in raster order, then init_done=1, busy=0.
REQ-035 IDLE, tile_req=score_req=1, frame_tick -> tile_gnt; tile plots (5,5,3'b000) -> vga out 1 cycle later; tile_done -> score_gnt next cycle; score_done -> IDLE.
REQ-036 During TILE, score_plot=1 at (10,10) -> no vga_plot; tile_plot at x=160 -> suppressed.
REQ-037 frame_tick during SCORE -> overrun=1, no extra grant; clear_req during TILE -> FILL entered after sequence ends.
REQ-038 tile_gnt held, no tile_done for 16384 cycles -> tile_gnt=0, timeout_err=1, SCORE or IDLE entered.
REQ-039 resetn=0 midway through a TILE grant -> gnt=0 next edge, fill restarts at (0,0).

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: shared screen geometry, colour codes, coordinate widths and scheduler state enum
package draw_pkg;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam logic [C_W-1:0] COL_WHITE = 3'b111;
  localparam logic [C_W-1:0] COL_BLACK = 3'b000;
  typedef enum logic [1:0] {FILL, IDLE, TILE, SCORE} state_t;
endpackage

// File: rtl/screen_fill.sv
// screen_fill: raster counter (start in; busy/done/x/y/colour out), x fastest, one pixel per cycle, busy out of reset
module screen_fill
  import draw_pkg::*;
#(
  parameter int             W      = SCREEN_W_DEF,
  parameter int             H      = SCREEN_H_DEF,
  parameter logic [C_W-1:0] COLOUR = COL_WHITE
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour
);
  logic           busy_q, busy_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end, last;
  always_comb begin
    x_end  = x_q == X_W'(W - 1);
    last   = busy_q && x_end && y_q == Y_W'(H - 1);
    busy_d = start ? 1'b1 : last ? 1'b0 : busy_q;
    x_d    = start || (busy_q && x_end) ? '0 : busy_q ? x_q + 1'b1 : x_q;
    y_d    = start || last ? '0 : busy_q && x_end ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b1;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end
  assign busy   = busy_q;
  assign done   = last;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = COLOUR;
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates tile/score clients and background fill onto a registered VGA pixel port (req/done/pixel in; gnt, vga_*, status out)
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int             SCREEN_W  = SCREEN_W_DEF,
  parameter int             SCREEN_H  = SCREEN_H_DEF,
  parameter logic [C_W-1:0] BG_COLOUR = COL_WHITE,
  parameter int             TIMEOUT   = 16384
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           clear_req,
  input  logic           tile_req,
  input  logic           score_req,
  input  logic [X_W-1:0] tile_x,
  input  logic [Y_W-1:0] tile_y,
  input  logic [C_W-1:0] tile_colour,
  input  logic           tile_plot,
  input  logic [X_W-1:0] score_x,
  input  logic [Y_W-1:0] score_y,
  input  logic [C_W-1:0] score_colour,
  input  logic           score_plot,
  input  logic           tile_done,
  input  logic           score_done,
  output logic           tile_gnt,
  output logic           score_gnt,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           init_done,
  output logic           busy,
  output logic           overrun,
  output logic           timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           pend_q, pend_d, init_q, init_d, ovr_q, ovr_d, tmo_q, tmo_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [C_W-1:0] vga_c_q, vga_c_d;
  logic           vga_p_q, vga_p_d;
  logic           fill_start, fill_busy, fill_done;
  logic [X_W-1:0] fill_x;
  logic [Y_W-1:0] fill_y;
  logic [C_W-1:0] fill_c;
  logic           clr, timed, client, done_in;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [C_W-1:0] cc;
  logic           cp;
  screen_fill #(.W(SCREEN_W), .H(SCREEN_H), .COLOUR(BG_COLOUR)) u_fill (
    .clk    (clk),
    .resetn (resetn),
    .start  (fill_start),
    .busy   (fill_busy),
    .done   (fill_done),
    .x      (fill_x),
    .y      (fill_y),
    .colour (fill_c)
  );
  always_comb begin
    clr        = pend_q || clear_req;
    timed      = cnt_q == CNT_W'(TIMEOUT - 1);
    client     = state_q == TILE || state_q == SCORE;
    done_in    = state_q == TILE ? tile_done : state_q == SCORE ? score_done : 1'b0;
    state_d    = state_q;
    fill_start = 1'b0;
    pend_d     = pend_q || clear_req;
    case (state_q)
      FILL:  state_d = fill_done ? IDLE : FILL;
      IDLE: begin
        if (clr) begin
          state_d    = FILL;
          fill_start = 1'b1;
          pend_d     = 1'b0;
        end else if (frame_tick) begin
          state_d = tile_req ? TILE : score_req ? SCORE : IDLE;
        end
      end
      TILE:  state_d = tile_done || timed ? (score_req ? SCORE : IDLE) : TILE;
      SCORE: state_d = score_done || timed ? IDLE : SCORE;
    endcase
    ovr_d  = ovr_q || (frame_tick && (state_q != IDLE || clr));
    tmo_d  = tmo_q || (client && timed && !done_in);
    init_d = init_q || state_d == IDLE;
    cnt_d  = client && state_d == state_q ? cnt_q + 1'b1 : '0;
    cx     = state_q == SCORE ? score_x : tile_x;
    cy     = state_q == SCORE ? score_y : tile_y;
    cc     = state_q == SCORE ? score_colour : tile_colour;
    cp     = state_q == SCORE ? score_plot : tile_plot;
    vga_p_d = state_q == FILL ? fill_busy :
              client && state_d == state_q && cp && 32'(cx) < SCREEN_W && 32'(cy) < SCREEN_H;
    vga_x_d = state_q == FILL ? fill_x : client ? cx : vga_x_q;
    vga_y_d = state_q == FILL ? fill_y : client ? cy : vga_y_q;
    vga_c_d = state_q == FILL ? fill_c : client ? cc : vga_c_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      init_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      vga_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      init_q  <= init_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
      vga_p_q <= vga_p_d;
    end
  end
  assign tile_gnt    = state_q == TILE;
  assign score_gnt   = state_q == SCORE;
  assign busy        = state_q != IDLE;
  assign init_done   = init_q;
  assign overrun     = ovr_q;
  assign timeout_err = tmo_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_c_q;
  assign vga_plot    = vga_p_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: randomized scenario bench for draw_scheduler with a behavioural pixel/arbitration model
module tb_draw_scheduler;
  import draw_pkg::*;
  localparam int W = 160, H = 120, TMO = 16384;
  logic clk = 0, resetn = 0;
  logic frame_tick = 0, clear_req = 0, tile_req = 0, score_req = 0;
  logic [7:0] tile_x = 0, score_x = 0;
  logic [6:0] tile_y = 0, score_y = 0;
  logic [2:0] tile_colour = 0, score_colour = 0;
  logic tile_plot = 0, score_plot = 0, tile_done = 0, score_done = 0;
  logic tile_gnt, score_gnt, vga_plot, init_done, busy, overrun, timeout_err;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int total = 0, bad = 0;
  draw_scheduler dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .clear_req(clear_req),
    .tile_req(tile_req), .score_req(score_req),
    .tile_x(tile_x), .tile_y(tile_y), .tile_colour(tile_colour), .tile_plot(tile_plot),
    .score_x(score_x), .score_y(score_y), .score_colour(score_colour), .score_plot(score_plot),
    .tile_done(tile_done), .score_done(score_done), .tile_gnt(tile_gnt), .score_gnt(score_gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .init_done(init_done), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_fill(output int n, output int errs);
    n = 0;
    errs = 0;
    for (int i = 0; i < 20000; i++) begin
      step;
      if (vga_plot) begin
        if (vga_colour !== COL_WHITE || vga_x !== 8'(n % W) || vga_y !== 7'(n / W)) errs++;
        n++;
      end
      if (!busy) break;
    end
  endtask
  task automatic test_reset;
    int n, errs;
    resetn = 0;
    repeat (3) step;
    total++;
    if ({tile_gnt, score_gnt, vga_plot, vga_x, vga_y, vga_colour, init_done, busy, overrun, timeout_err} !== 26'b1_0_0) begin
      bad++;
      $display("FAIL reset_state: got gnt=%b%b plot=%b x=%0d y=%0d c=%0d init=%b busy=%b ovr=%b tmo=%b, want all 0 except busy=1",
               tile_gnt, score_gnt, vga_plot, vga_x, vga_y, vga_colour, init_done, busy, overrun, timeout_err);
    end
    resetn = 1;
    wait_fill(n, errs);
    total++;
    if (n !== W * H) begin bad++; $display("FAIL init_fill_count: got %0d want %0d", n, W * H); end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL init_fill_raster: got %0d bad pixels want 0", errs); end
    total++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL init_done: got init=%b busy=%b want 1 0", init_done, busy); end
    step;
    total++;
    if (vga_plot !== 1'b0) begin bad++; $display("FAIL idle_plot: got %b want 0", vga_plot); end
  endtask
  task automatic test_basic;
    frame_tick = 1; tile_req = 1; score_req = 1;
    step;
    frame_tick = 0;
    total++;
    if (tile_gnt !== 1'b1 || score_gnt !== 1'b0) begin bad++; $display("FAIL tile_grant: got %b%b want 10", tile_gnt, score_gnt); end
    tile_x = 5; tile_y = 5; tile_colour = COL_BLACK; tile_plot = 1;
    step;
    tile_plot = 0;
    total++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd5, 7'd5, 3'd0})
      begin bad++; $display("FAIL tile_pixel: got p=%b (%0d,%0d) c=%0d want 1 (5,5) c=0", vga_plot, vga_x, vga_y, vga_colour); end
    tile_done = 1;
    step;
    tile_done = 0;
    total++;
    if (tile_gnt !== 1'b0 || score_gnt !== 1'b1) begin bad++; $display("FAIL score_grant: got %b%b want 01", tile_gnt, score_gnt); end
    score_x = 7; score_y = 8; score_colour = 3'd2; score_plot = 1;
    step;
    score_plot = 0;
    total++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd7, 7'd8, 3'd2})
      begin bad++; $display("FAIL score_pixel: got p=%b (%0d,%0d) c=%0d want 1 (7,8) c=2", vga_plot, vga_x, vga_y, vga_colour); end
    score_done = 1;
    step;
    score_done = 0; tile_req = 0; score_req = 0;
    total++;
    if (busy !== 1'b0 || score_gnt !== 1'b0) begin bad++; $display("FAIL score_release: got busy=%b gnt=%b want 0 0", busy, score_gnt); end
  endtask
  task automatic test_isolation;
    logic ep;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    frame_tick = 1; tile_req = 1;
    step;
    frame_tick = 0;
    score_x = 10; score_y = 10; score_plot = 1;
    step;
    score_plot = 0;
    total++;
    if (vga_plot !== 1'b0) begin bad++; $display("FAIL foreign_plot: got %b want 0", vga_plot); end
    tile_x = 160; tile_y = 5; tile_plot = 1;
    step;
    total++;
    if (vga_plot !== 1'b0) begin bad++; $display("FAIL x_range: got %b want 0", vga_plot); end
    tile_x = 20; tile_y = 120;
    step;
    tile_plot = 0;
    total++;
    if (vga_plot !== 1'b0) begin bad++; $display("FAIL y_range: got %b want 0", vga_plot); end
    score_done = 1;
    step;
    score_done = 0;
    total++;
    if (tile_gnt !== 1'b1) begin bad++; $display("FAIL foreign_done: got tile_gnt=%b want 1", tile_gnt); end
    for (int i = 0; i < 200; i++) begin
      tile_x = 8'($urandom_range(0, 200)); tile_y = 7'($urandom_range(0, 127));
      tile_colour = 3'($urandom); tile_plot = 1'($urandom);
      score_x = 8'($urandom_range(0, 159)); score_y = 7'($urandom_range(0, 119)); score_plot = 1'($urandom);
      ep = tile_plot && int'(tile_x) < W && int'(tile_y) < H;
      ex = tile_x; ey = tile_y; ec = tile_colour;
      step;
      total++;
      if (vga_plot !== ep || (ep && {vga_x, vga_y, vga_colour} !== {ex, ey, ec}))
        begin bad++; $display("FAIL rand_pixel[%0d]: got p=%b (%0d,%0d) c=%0d want p=%b (%0d,%0d) c=%0d", i, vga_plot, vga_x, vga_y, vga_colour, ep, ex, ey, ec); end
    end
    tile_x = 3; tile_y = 3; tile_plot = 1; tile_done = 1; score_plot = 0;
    step;
    tile_plot = 0; tile_done = 0; tile_req = 0;
    total++;
    if (busy !== 1'b0 || tile_gnt !== 1'b0 || vga_plot !== 1'b0)
      begin bad++; $display("FAIL tile_exit: got busy=%b gnt=%b plot=%b want 0 0 0", busy, tile_gnt, vga_plot); end
  endtask
  task automatic test_overrun;
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    frame_tick = 1; score_req = 1;
    step;
    tile_req = 1;
    step;
    frame_tick = 0;
    total++;
    if (overrun !== 1'b1 || score_gnt !== 1'b1 || tile_gnt !== 1'b0)
      begin bad++; $display("FAIL overrun_set: got ovr=%b gnt=%b%b want 1 01", overrun, tile_gnt, score_gnt); end
    score_done = 1;
    step;
    score_done = 0;
    step;
    total++;
    if (busy !== 1'b0 || tile_gnt !== 1'b0) begin bad++; $display("FAIL no_extra_grant: got busy=%b tile_gnt=%b want 0 0", busy, tile_gnt); end
    tile_req = 0; score_req = 0;
  endtask
  task automatic test_timeout;
    int n;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    frame_tick = 1; tile_req = 1; score_req = 1;
    step;
    frame_tick = 0;
    n = 0;
    while (tile_gnt && n < TMO + 100) begin n++; step; end
    total++;
    if (n !== TMO) begin bad++; $display("FAIL timeout_len: got %0d grant cycles want %0d", n, TMO); end
    total++;
    if (timeout_err !== 1'b1 || score_gnt !== 1'b1)
      begin bad++; $display("FAIL timeout_advance: got tmo=%b score_gnt=%b want 1 1", timeout_err, score_gnt); end
    score_done = 1;
    step;
    score_done = 0; tile_req = 0; score_req = 0;
  endtask
  task automatic test_clear;
    int n, errs;
    frame_tick = 1; tile_req = 1;
    step;
    frame_tick = 0; clear_req = 1;
    step;
    clear_req = 0;
    step;
    clear_req = 1;
    step;
    clear_req = 0;
    total++;
    if (tile_gnt !== 1'b1) begin bad++; $display("FAIL clear_defer: got tile_gnt=%b want 1", tile_gnt); end
    tile_done = 1;
    step;
    tile_done = 0; tile_req = 0;
    step;
    total++;
    if (busy !== 1'b1 || tile_gnt !== 1'b0) begin bad++; $display("FAIL clear_fill_start: got busy=%b gnt=%b want 1 0", busy, tile_gnt); end
    wait_fill(n, errs);
    total++;
    if (n !== W * H || errs !== 0) begin bad++; $display("FAIL clear_fill: got %0d plots %0d bad want %0d 0", n, errs, W * H); end
    repeat (3) step;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clear_collapse: got busy=%b want 0", busy); end
  endtask
  task automatic test_reset_mid_grant;
    frame_tick = 1; tile_req = 1;
    step;
    frame_tick = 0;
    tile_x = 9; tile_y = 9; tile_plot = 1;
    resetn = 0;
    step;
    tile_plot = 0;
    total++;
    if ({tile_gnt, busy, vga_plot, init_done, overrun, timeout_err} !== 6'b010000)
      begin bad++; $display("FAIL mid_reset: got gnt=%b busy=%b plot=%b init=%b ovr=%b tmo=%b want 0 1 0 0 0 0", tile_gnt, busy, vga_plot, init_done, overrun, timeout_err); end
    resetn = 1; tile_req = 0;
    step;
    total++;
    if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd0, 7'd0}) begin bad++; $display("FAIL refill_origin: got p=%b (%0d,%0d) want 1 (0,0)", vga_plot, vga_x, vga_y); end
    step;
    total++;
    if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd1, 7'd0}) begin bad++; $display("FAIL refill_next: got p=%b (%0d,%0d) want 1 (1,0)", vga_plot, vga_x, vga_y); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_isolation;
    test_overrun;
    test_timeout;
    test_clear;
    test_reset_mid_grant;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
